// File: rtl/esp_sequencer_if.sv
// Handshake/bus bundle between the core's control path and the ESP sequencer.
// The sequencer takes the slave view; the core/bench takes the master view.
interface esp_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        Opcode;
  logic              valid_in;
  logic              done;
  logic [DATA_W-1:0] result_in;
  logic              Stall;
  logic              start;
  logic              WriteRegESP;
  logic [DATA_W-1:0] result_out;
  logic              timeout_err;
  logic [7:0]        op_count;
  logic [1:0]        state_dbg;

  modport master (
    output Opcode, valid_in, done, result_in,
    input  Stall, start, WriteRegESP, result_out, timeout_err, op_count, state_dbg
  );

  modport slave (
    input  Opcode, valid_in, done, result_in,
    output Stall, start, WriteRegESP, result_out, timeout_err, op_count, state_dbg
  );
endinterface

// File: rtl/esp_sequencer.sv
// Multi-cycle sequencer for the specialized-module opcode: stalls the core,
// pulses start, waits for done (bounded by a timeout) and issues one write strobe.
module esp_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  esp_sequencer_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] OPC_ESP = 5'b10110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_success;
  logic [DATA_W-1:0] r_result;
  logic              r_timeout_err;
  logic [7:0]        r_op_count;

  logic       w_launch;
  logic       w_cnt_last;
  logic [1:0] w_state_next;

  assign w_launch   = (r_state == S_IDLE) && bus.valid_in && (bus.Opcode == OPC_ESP);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      // done on the last WAIT cycle still counts as success
      S_WAIT:  if (bus.done || w_cnt_last) w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_success     <= 1'b0;
      r_result      <= '0;
      r_timeout_err <= 1'b0;
      r_op_count    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_launch) r_timeout_err <= 1'b0;
        end
        S_START: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (bus.done) begin
            r_result  <= bus.result_in;
            r_success <= 1'b1;
          end else if (w_cnt_last) begin
            r_timeout_err <= 1'b1;
            r_success     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_success) r_op_count <= r_op_count + 8'd1;
        end
      endcase
    end
  end

  // start/WriteRegESP come straight from registered state, so they are glitch-free
  assign bus.start       = (r_state == S_START);
  assign bus.WriteRegESP = (r_state == S_WRITE) && r_success;
  assign bus.Stall       = w_launch || (r_state == S_START) || (r_state == S_WAIT);
  assign bus.result_out  = r_result;
  assign bus.timeout_err = r_timeout_err;
  assign bus.op_count    = r_op_count;
  assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_esp_sequencer.sv
// Directed bench for esp_sequencer: one instance with the default timeout and
// one with TIMEOUT_CYCLES=4 for the abort path.
module tb_esp_sequencer;
  localparam logic [4:0] ESP = 5'b10110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  esp_sequencer_if #(.DATA_W(32)) bus ();
  esp_sequencer_if #(.DATA_W(32)) bus_t ();

  esp_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(255)) dut (.clk(clk), .rst(rst), .bus(bus));
  esp_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(4))   dut_t (.clk(clk), .rst(rst), .bus(bus_t));

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int start_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] op, input logic d, input logic [31:0] r);
    bus.valid_in  = v;
    bus.Opcode    = op;
    bus.done      = d;
    bus.result_in = r;
  endtask

  task automatic drv_t(input logic v, input logic [4:0] op, input logic d, input logic [31:0] r);
    bus_t.valid_in  = v;
    bus_t.Opcode    = op;
    bus_t.done      = d;
    bus_t.result_in = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drv(1'b0, 5'd0, 1'b0, 32'd0);
    drv_t(1'b0, 5'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_wr", 32'(bus.WriteRegESP), 32'd0);
    chk("rst_result", bus.result_out, 32'd0);
    chk("rst_opcount", 32'(bus.op_count), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
    $display("reset: checks=%0d", checks);

    // rst asserted in WAIT cycle 2 aborts without a write
    tick(); drv(1'b1, ESP, 1'b0, 32'd0); #1;
    chk("abort_launch_stall", 32'(bus.Stall), 32'd1);
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("abort_start_state", 32'(bus.state_dbg), 32'd1);
    tick(); tick(); tick(); #1;
    chk("abort_wait2_state", 32'(bus.state_dbg), 32'd2);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("abort_state", 32'(bus.state_dbg), 32'd0);
    chk("abort_stall", 32'(bus.Stall), 32'd0);
    chk("abort_start", 32'(bus.start), 32'd0);
    chk("abort_wr", 32'(bus.WriteRegESP), 32'd0);
    chk("abort_opcount", 32'(bus.op_count), 32'd0);
    chk("abort_result", bus.result_out, 32'd0);
    tick(); #1;
    chk("abort_no_wr", 32'(bus.WriteRegESP), 32'd0);
    chk("abort_idle", 32'(bus.state_dbg), 32'd0);
    $display("reset during WAIT: checks=%0d errors=%0d", checks, errors);

    // minimum-latency success
    tick(); drv(1'b1, ESP, 1'b0, 32'd0); #1;
    chk("t1_T_stall", 32'(bus.Stall), 32'd1);
    chk("t1_T_start", 32'(bus.start), 32'd0);
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t1_T1_start", 32'(bus.start), 32'd1);
    chk("t1_T1_stall", 32'(bus.Stall), 32'd1);
    tick(); drv(1'b0, 5'd0, 1'b1, 32'hDEADBEEF); #1;
    chk("t1_T2_stall", 32'(bus.Stall), 32'd1);
    chk("t1_T2_start", 32'(bus.start), 32'd0);
    chk("t1_T2_state", 32'(bus.state_dbg), 32'd2);
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t1_T3_wr", 32'(bus.WriteRegESP), 32'd1);
    chk("t1_T3_result", bus.result_out, 32'hDEADBEEF);
    chk("t1_T3_stall", 32'(bus.Stall), 32'd0);
    chk("t1_T3_state", 32'(bus.state_dbg), 32'd3);
    tick(); #1;
    chk("t1_T4_wr", 32'(bus.WriteRegESP), 32'd0);
    chk("t1_T4_opcount", 32'(bus.op_count), 32'd1);
    chk("t1_T4_state", 32'(bus.state_dbg), 32'd0);
    $display("single op: checks=%0d errors=%0d", checks, errors);

    // done in IDLE and START ignored; done at WAIT cycle 5
    tick(); drv(1'b0, 5'd0, 1'b1, 32'hFFFF0000); #1;
    chk("t2_idle_done_stall", 32'(bus.Stall), 32'd0);
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t2_idle_done_state", 32'(bus.state_dbg), 32'd0);
    chk("t2_idle_done_wr", 32'(bus.WriteRegESP), 32'd0);
    stall_cnt = 0;
    start_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      drv(c == 0, (c == 0) ? ESP : 5'd0, (c == 1) || (c == 7), (c == 7) ? 32'h12345678 : 32'd0);
      #1;
      stall_cnt += int'(bus.Stall);
      start_cnt += int'(bus.start);
      chk("t2_wr", 32'(bus.WriteRegESP), 32'(c == 8));
      if (c == 2) chk("t2_start_done_ignored", 32'(bus.state_dbg), 32'd2);
    end
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t2_stall_cycles", 32'(stall_cnt), 32'd8);
    chk("t2_start_pulses", 32'(start_cnt), 32'd1);
    chk("t2_result", bus.result_out, 32'h12345678);
    chk("t2_opcount", 32'(bus.op_count), 32'd2);
    chk("t2_state", 32'(bus.state_dbg), 32'd0);
    $display("delayed done: checks=%0d errors=%0d", checks, errors);

    // timeout path on the TIMEOUT_CYCLES=4 instance
    tick(); drv_t(1'b1, ESP, 1'b0, 32'd0);
    tick(); drv_t(1'b0, 5'd0, 1'b0, 32'd0);
    tick(); drv_t(1'b0, 5'd0, 1'b1, 32'hA5A5A5A5);
    tick(); drv_t(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t3_pre_wr", 32'(bus_t.WriteRegESP), 32'd1);
    tick(); #1;
    chk("t3_pre_opcount", 32'(bus_t.op_count), 32'd1);
    chk("t3_pre_result", bus_t.result_out, 32'hA5A5A5A5);
    for (int c = 0; c < 7; c++) begin
      tick();
      drv_t(c == 0, (c == 0) ? ESP : 5'd0, 1'b0, 32'd0);
      #1;
      chk("t3_wr", 32'(bus_t.WriteRegESP), 32'd0);
      if (c == 5) begin
        chk("t3_last_wait_state", 32'(bus_t.state_dbg), 32'd2);
        chk("t3_last_wait_tmo", 32'(bus_t.timeout_err), 32'd0);
      end
      if (c == 6) begin
        chk("t3_write_state", 32'(bus_t.state_dbg), 32'd3);
        chk("t3_write_tmo", 32'(bus_t.timeout_err), 32'd1);
        chk("t3_write_stall", 32'(bus_t.Stall), 32'd0);
        chk("t3_write_result", bus_t.result_out, 32'hA5A5A5A5);
      end
    end
    tick(); drv_t(1'b0, 5'd0, 1'b1, 32'hBAD0BAD0); #1;
    chk("t3_late_done_state", 32'(bus_t.state_dbg), 32'd0);
    tick(); drv_t(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t3_late_state", 32'(bus_t.state_dbg), 32'd0);
    chk("t3_late_wr", 32'(bus_t.WriteRegESP), 32'd0);
    chk("t3_late_result", bus_t.result_out, 32'hA5A5A5A5);
    chk("t3_late_opcount", 32'(bus_t.op_count), 32'd1);
    chk("t3_sticky_tmo", 32'(bus_t.timeout_err), 32'd1);
    tick(); drv_t(1'b1, ESP, 1'b0, 32'd0); #1;
    chk("t3_relaunch_tmo_T", 32'(bus_t.timeout_err), 32'd1);
    tick(); drv_t(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t3_relaunch_tmo_T1", 32'(bus_t.timeout_err), 32'd0);
    chk("t3_relaunch_start", 32'(bus_t.start), 32'd1);
    tick(); drv_t(1'b0, 5'd0, 1'b1, 32'hC0FFEE00);
    tick(); drv_t(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t3_relaunch_wr", 32'(bus_t.WriteRegESP), 32'd1);
    chk("t3_relaunch_result", bus_t.result_out, 32'hC0FFEE00);
    tick(); #1;
    chk("t3_relaunch_opcount", 32'(bus_t.op_count), 32'd2);
    $display("timeout: checks=%0d errors=%0d", checks, errors);

    // other opcodes and bubbles never stall
    for (int c = 0; c < 3; c++) begin
      tick(); drv(1'b1, 5'd0, 1'b0, 32'd0); #1;
      chk("t6_op0_stall", 32'(bus.Stall), 32'd0);
      chk("t6_op0_state", 32'(bus.state_dbg), 32'd0);
    end
    tick(); drv(1'b0, ESP, 1'b0, 32'd0); #1;
    chk("t6_bubble_stall", 32'(bus.Stall), 32'd0);
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t6_bubble_state", 32'(bus.state_dbg), 32'd0);

    // 256 back-to-back launches, op_count wraps
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t5_rst_opcount", 32'(bus.op_count), 32'd0);
    start_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        drv(1'b1, ESP, c == 2, (c == 2) ? 32'(i) : 32'd0);
        #1;
        start_cnt += int'(bus.start);
        if (c == 0) begin
          chk("t5_launch_state", 32'(bus.state_dbg), 32'd0);
          chk("t5_launch_stall", 32'(bus.Stall), 32'd1);
        end
        if (c == 3) begin
          chk("t5_wr", 32'(bus.WriteRegESP), 32'd1);
          chk("t5_write_stall", 32'(bus.Stall), 32'd0);
          chk("t5_result", bus.result_out, 32'(i));
          chk("t5_opcount", 32'(bus.op_count), 32'(i % 256));
        end
      end
    end
    tick(); drv(1'b0, 5'd0, 1'b0, 32'd0); #1;
    chk("t5_wrap_opcount", 32'(bus.op_count), 32'd0);
    chk("t5_start_pulses", 32'(start_cnt), 32'd256);
    chk("t5_end_state", 32'(bus.state_dbg), 32'd0);
    $display("back-to-back: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
